// File: rtl/imem_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
package imem_pkg;

   localparam int unsigned IMEM_DEPTH = 64;
   localparam int unsigned WORD_W     = 32;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECV,
      ST_WRITE,
      ST_DONE
   } loader_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Little-endian byte packer: four accepted bytes form one 32-bit word, first byte in [7:0].
module imem_byte_packer
   import imem_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              accept,
   input  logic [7:0]        byte_data,
   output logic [WORD_W-1:0] word,
   output logic              last
);

   logic [1:0]        idx_q;
   logic [WORD_W-1:0] shift_q;

   assign word = shift_q;
   assign last = accept && (idx_q == 2'd3);

   // Bytes enter at the top and shift down, so after four the first one sits in [7:0].
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         idx_q   <= '0;
         shift_q <= '0;
      end else if (accept) begin
         idx_q   <= idx_q + 2'd1;
         shift_q <= {byte_data, shift_q[WORD_W-1:8]};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory, one word per WRITE cycle,
// holding the CPU in reset until the session completes.
module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH = IMEM_DEPTH,
   parameter int unsigned AW    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [6:0]        load_len,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              wr_en,
   output logic [AW-1:0]     wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic [6:0]        word_count,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              cpu_hold
);

   loader_state_t     state, state_next;
   logic [6:0]        len_q;
   logic [6:0]        count_q;
   logic              err_q;
   logic [AW-1:0]     addr_q;
   logic [WORD_W-1:0] data_q;
   logic              len_bad;
   logic              start_ok;
   logic              pk_clear;
   logic              pk_last;
   logic              accept;
   logic [WORD_W-1:0] pk_word;
   logic [AW-1:0]     cur_addr;

   assign len_bad  = (32'(load_len) > DEPTH);
   assign accept   = byte_valid && byte_ready;
   assign cur_addr = AW'({count_q, 2'b00});

   imem_byte_packer u_packer (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (pk_clear),
      .accept    (accept),
      .byte_data (byte_data),
      .word      (pk_word),
      .last      (pk_last)
   );

   always_comb begin
      state_next = state;
      start_ok   = 1'b0;
      pk_clear   = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start && !len_bad) begin
               start_ok = 1'b1;
               if (load_len == '0) begin
                  state_next = ST_DONE;
               end else begin
                  state_next = ST_RECV;
                  pk_clear   = 1'b1;
               end
            end
         end
         ST_RECV:  if (pk_last) state_next = ST_WRITE;
         ST_WRITE: state_next = (count_q + 7'd1 == len_q) ? ST_DONE : ST_RECV;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         len_q   <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state <= state_next;
         if ((state == ST_IDLE || state == ST_DONE) && start)
            err_q <= len_bad;
         if (start_ok) begin
            len_q   <= load_len;
            count_q <= '0;
         end
         if (state == ST_WRITE) begin
            addr_q  <= cur_addr;
            data_q  <= pk_word;
            count_q <= count_q + 7'd1;
         end
      end
   end

   // The live word/address drive the bus during WRITE; the registers keep them afterwards.
   assign wr_en      = (state == ST_WRITE);
   assign wr_addr    = wr_en ? cur_addr : addr_q;
   assign wr_data    = wr_en ? pk_word  : data_q;
   assign byte_ready = (state == ST_RECV);
   assign word_count = count_q;
   assign busy       = (state == ST_RECV) || (state == ST_WRITE);
   assign done       = (state == ST_DONE);
   assign err        = err_q;
   assign cpu_hold   = (state != ST_DONE);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of 32-bit instruction words in the target memory.
REQ-002 SHALL have parameter AW, default 32, meaning the width of the byte write address.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: begin a load session; sampled only in IDLE or DONE.
REQ-006 SHALL have port load_len, input, 7 bits: number of words to load; latched when start is accepted.
REQ-007 SHALL have port byte_valid, input, 1 bit: byte_data holds a valid byte.
REQ-008 SHALL have port byte_data, input, 8 bits: incoming program byte.
REQ-009 SHALL have port byte_ready, output, 1 bit: the loader accepts a byte this cycle.
REQ-010 SHALL have port wr_en, output, 1 bit: write strobe to the instruction memory.
REQ-011 SHALL have port wr_addr, output, AW bits: word-aligned byte address; the memory indexes by wr_addr[7:2].
REQ-012 SHALL have port wr_data, output, 32 bits: assembled instruction word.
REQ-013 SHALL have port word_count, output, 7 bits: words written in the current session.
REQ-014 SHALL have port busy, output, 1 bit: high in RECV and WRITE.
REQ-015 SHALL have port done, output, 1 bit: high in DONE.
REQ-016 SHALL have port err, output, 1 bit: the last start was rejected because load_len > DEPTH.
REQ-017 SHALL have port cpu_hold, output, 1 bit: keeps the processor in reset until a load completes.

Function
REQ-018 SHALL implement the states IDLE, RECV, WRITE and DONE.
REQ-019 IDLE/DONE + start: if load_len > DEPTH, SHALL set err=1 and stay in the current state; if load_len == 0, SHALL go to DONE and set err=0; otherwise SHALL go to RECV, set err=0, clear word_count and clear the byte index.
REQ-020 byte_ready SHALL be 1 only in RECV; a byte is accepted when byte_valid && byte_ready.
REQ-021 Bytes SHALL be packed little-endian: the first byte goes to bits [7:0] and the fourth byte goes to bits [31:24].
REQ-022 On the fourth accepted byte the FSM SHALL move to WRITE; in WRITE, wr_en SHALL be 1 for exactly one cycle with wr_addr = word_count*4 and wr_data = the packed word.
REQ-023 After WRITE, word_count SHALL increment; if the new count equals the latched length, the FSM SHALL go to DONE, otherwise to RECV.
REQ-024 Throughput SHALL be one word per 5 cycles when bytes arrive back-to-back; gaps in byte_valid SHALL only stall the loader.
REQ-025 start SHALL be ignored in RECV and WRITE.
REQ-026 cpu_hold SHALL be 1 in IDLE, RECV and WRITE, and 0 in DONE; a restart from DONE SHALL reassert it.
REQ-027 wr_en SHALL be 0 outside WRITE; wr_addr and wr_data SHALL hold their last values.
REQ-028 word_count SHALL never exceed DEPTH, and wr_addr SHALL never reach DEPTH*4.

Reset
REQ-029 With rst_n=0 at a clock edge, the block SHALL enter IDLE with byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, word_count=0, busy=0, done=0, err=0 and cpu_hold=1.
REQ-030 A reset during RECV or WRITE SHALL abandon the session: partial bytes are discarded and no write is issued in the reset cycle.

Structure
REQ-031 A shared package imem_pkg SHALL hold the DEPTH default, a word-width constant of 32 and the loader state enumeration.
REQ-032 The byte packer SHALL be one sub-module, imem_byte_packer, containing the 2-bit byte index and the 32-bit shift/assembly register with clear and accept inputs; the FSM and counters stay in imem_loader.

Verification
REQ-033 Load of 3 words: load_len=3 with bytes 33,86,90,01 / B3,02,34,40 / B3,70,31,00 back-to-back -> writes 0x01908633@0x0, 0x403402B3@0x4 and 0x003170B3@0x8, then done=1 and cpu_hold=0 at cycle 16 after start.
REQ-034 Stalled stream: the same load with byte_valid low for 5 cycles between each byte -> identical writes, and wr_en occurs only in WRITE.
REQ-035 Bad length: start with load_len=65 -> err=1, state unchanged, no wr_en; a following start with load_len=0 -> done=1 and err=0.
REQ-036 Reset mid-word: 2 bytes accepted, then rst_n=0 for 1 cycle -> IDLE with all outputs at reset values; a new 1-word load gives a clean word at 0x0.
REQ-037 Start while busy: a second start pulse with load_len=5 during a 2-word session -> ignored; exactly 2 writes occur.
REQ-038 Full memory: load_len=64 -> last write at 0xFC, word_count=64 and done=1.
